// File: rtl/reg_dump_pkg.sv
// Shared types for the register file dump unit: state encoding and defaults.
// DUMP_CHECKSUM_EN adds the CHECK state used for the trailing checksum beat.
package reg_dump_pkg;

  localparam int REG_COUNT_DEF = 32;
  localparam int ADDR_W = 5;

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    DONE,
    CHECK
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;
`endif

endpackage

// File: rtl/reg_dump_xor_accum.sv
// XOR accumulator folding each captured register word into a running checksum.
// Ports: clk, reset (sync, high), clear, en, din[N], acc[N].
module reg_dump_xor_accum #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [N-1:0] din,
  output logic [N-1:0] acc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/reg_file_dump_unit.sv
// Streams registers 0..REG_COUNT-1 from one register file read port as
// valid/ready beats. Ports: clk, reset, start_i, Read_Register_o,
// Read_Data_i, dump_valid_o/ready_i/data_o/index_o/last_o, busy_o, done_o.
// DUMP_CHECKSUM_EN appends an XOR checksum beat (index 0, last=1).
module reg_file_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int N         = 32,
  parameter int REG_COUNT = REG_COUNT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  output logic [4:0]   Read_Register_o,
  input  logic [N-1:0] Read_Data_i,
  output logic         dump_valid_o,
  input  logic         dump_ready_i,
  output logic [N-1:0] dump_data_o,
  output logic [4:0]   dump_index_o,
  output logic         dump_last_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(REG_COUNT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              hs;

  assign hs = dump_valid_o & dump_ready_i;

  // The read port address is the counter itself; it is only consumed in LOAD.
  assign Read_Register_o = addr;

`ifdef DUMP_CHECKSUM_EN
  logic [N-1:0] acc;
  logic         acc_clr;
  logic         acc_en;

  assign acc_clr = (state == IDLE) && start_i;
  assign acc_en  = (state == LOAD);

  reg_dump_xor_accum #(
    .N(N)
  ) u_accum (
    .clk  (clk),
    .reset(reset),
    .clear(acc_clr),
    .en   (acc_en),
    .din  (Read_Data_i),
    .acc  (acc)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      dump_valid_o <= 1'b0;
      dump_data_o  <= '0;
      dump_index_o <= '0;
      dump_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            addr   <= '0;
            busy_o <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          dump_data_o  <= Read_Data_i;
          dump_index_o <= addr;
          dump_valid_o <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          dump_last_o  <= 1'b0;
`else
          dump_last_o  <= (addr == LAST_A);
`endif
          state        <= SEND;
        end
        SEND: begin
          if (hs) begin
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
            if (addr < LAST_A) begin
              addr  <= addr + 1'b1;
              state <= LOAD;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              // Checksum beat follows immediately, no LOAD gap.
              dump_valid_o <= 1'b1;
              dump_data_o  <= acc;
              dump_index_o <= '0;
              dump_last_o  <= 1'b1;
              state        <= CHECK;
`else
              done_o <= 1'b1;
              state  <= DONE;
`endif
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CHECK: begin
          if (hs) begin
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
            done_o       <= 1'b1;
            state        <= DONE;
          end
        end
`endif
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dump_unit.sv
// Testbench for reg_file_dump_unit: register file model, directed and
// random-ready dumps checked against per-beat expectations.
module tb_reg_file_dump_unit;

  localparam int N  = 32;
  localparam int RC = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif
  localparam int NB = RC + (CKS ? 1 : 0);

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [4:0]   Read_Register_o;
  logic [N-1:0] Read_Data_i;
  logic         dump_valid_o;
  logic         dump_ready_i;
  logic [N-1:0] dump_data_o;
  logic [4:0]   dump_index_o;
  logic         dump_last_o;
  logic         busy_o;
  logic         done_o;

  logic [N-1:0] regs [RC];
  logic [N-1:0] mdl  [RC];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign Read_Data_i = regs[Read_Register_o];

  reg_file_dump_unit #(
    .N(N),
    .REG_COUNT(RC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .Read_Register_o(Read_Register_o),
    .Read_Data_i    (Read_Data_i),
    .dump_valid_o   (dump_valid_o),
    .dump_ready_i   (dump_ready_i),
    .dump_data_o    (dump_data_o),
    .dump_index_o   (dump_index_o),
    .dump_last_o    (dump_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] xor_all();
    logic [N-1:0] x = '0;
    for (int k = 0; k < RC; k++) x ^= mdl[k];
    return x;
  endfunction

  // directed: stall beat 7, restart pulse at beat 10, write x5 at beat 2
  task automatic dump(input bit directed, input bit rnd, input int abort_at);
    int  beat = 0;
    int  stall = 0;
    bit  gap = 0;
    bit  restarted = 0;
    logic [N-1:0] ed;
    logic [4:0]   ei;
    logic         el;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("lat_load_valid", N'(dump_valid_o), N'(0));
    chk("busy_load", N'(busy_o), N'(1));
    @(negedge clk);
    for (int cyc = 0; cyc < 4000 && beat < NB; cyc++) begin
      if (gap) begin
        chk("gap_valid", N'(dump_valid_o), N'(0));
        gap = 1'b0;
      end else begin
        chk("valid", N'(dump_valid_o), N'(1));
        if (beat == abort_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          chk("abort_busy", N'(busy_o), N'(0));
          chk("abort_valid", N'(dump_valid_o), N'(0));
          chk("abort_done", N'(done_o), N'(0));
          chk("abort_raddr", N'(Read_Register_o), N'(0));
          @(negedge clk);
          chk("abort_done2", N'(done_o), N'(0));
          return;
        end
        if (beat < RC) begin
          ed = mdl[beat];
          ei = 5'(beat);
          el = (beat == RC - 1) && !CKS;
        end else begin
          ed = xor_all();
          ei = 5'd0;
          el = 1'b1;
        end
        chk($sformatf("data_%0d", beat), dump_data_o, ed);
        chk($sformatf("index_%0d", beat), N'(dump_index_o), N'(ei));
        chk($sformatf("last_%0d", beat), N'(dump_last_o), N'(el));
        chk("done_quiet", N'(done_o), N'(0));
        if (directed && beat == 2) begin
          regs[5] = 32'hDEAD_BEEF;
          mdl[5]  = 32'hDEAD_BEEF;
        end
        if (directed && beat == 7 && stall < 5) begin
          dump_ready_i = 1'b0;
          stall++;
        end else begin
          dump_ready_i = rnd ? 1'($urandom % 2) : 1'b1;
        end
        if (directed && beat == 10 && !restarted) begin
          start_i = 1'b1;
          restarted = 1'b1;
        end
        if (dump_ready_i) begin
          beat++;
          gap = (beat < RC);
        end
      end
      @(negedge clk);
      start_i = 1'b0;
    end
    dump_ready_i = 1'b0;
    chk("timeout", N'(beat), N'(NB));
    chk("done_pulse", N'(done_o), N'(1));
    chk("done_valid", N'(dump_valid_o), N'(0));
    @(negedge clk);
    chk("done_clear", N'(done_o), N'(0));
    chk("idle_busy", N'(busy_o), N'(0));
  endtask

  initial begin
    reset = 1'b1;
    start_i = 1'b0;
    dump_ready_i = 1'b0;
    for (int k = 0; k < RC; k++) regs[k] = N'(k);
    regs[2] = 32'h1001_03FC;
    for (int k = 0; k < RC; k++) mdl[k] = regs[k];
    repeat (2) @(negedge clk);
    chk("rst_valid", N'(dump_valid_o), N'(0));
    chk("rst_busy", N'(busy_o), N'(0));
    chk("rst_done", N'(done_o), N'(0));
    chk("rst_raddr", N'(Read_Register_o), N'(0));
    chk("rst_data", dump_data_o, N'(0));
    chk("rst_index", N'(dump_index_o), N'(0));
    chk("rst_last", N'(dump_last_o), N'(0));
    reset = 1'b0;
    @(negedge clk);

    dump(1'b1, 1'b0, -1);
    dump(1'b0, 1'b0, 15);

    for (int k = 1; k < RC; k++) regs[k] = N'($urandom);
    regs[0] = '0;
    for (int k = 0; k < RC; k++) mdl[k] = regs[k];
    dump(1'b0, 1'b1, -1);
    dump(1'b0, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_dump_unit.md
REG_FILE_DUMP_UNIT -- requirements
Module: reg_file_dump_unit

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the data width of the register file read port.
REQ-002 The block SHALL have parameter REG_COUNT, default 32, giving the number of registers dumped.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start_i  input  1  one-cycle request to begin a dump.
REQ-007 Read_Register_o  output  5  address driven to one register file read port.
REQ-008 Read_Data_i  input  N  combinational read data from that port.
REQ-009 dump_valid_o  output  1  output beat valid.
REQ-010 dump_ready_i  input  1  consumer accepts the beat.
REQ-011 dump_data_o  output  N  beat data.
REQ-012 dump_index_o  output  5  register index of the beat.
REQ-013 dump_last_o  output  1  marks the final beat of the dump.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 done_o  output  1  one-cycle pulse when the dump completes.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, SEND and DONE, plus CHECK when DUMP_CHECKSUM_EN is defined.
REQ-017 In IDLE, start_i=1 SHALL clear the address counter to 0 and enter LOAD on the next edge.
REQ-018 start_i SHALL be ignored in every state except IDLE.
REQ-019 In LOAD, Read_Register_o SHALL equal the address counter, and Read_Data_i SHALL be registered into dump_data_o at the clock edge; the FSM then enters SEND.
REQ-020 In SEND:
- dump_valid_o SHALL be 1.
- dump_data_o and dump_index_o SHALL hold stable until dump_valid_o and dump_ready_i are both high.
REQ-021 The latency from a start_i edge to the first dump_valid_o SHALL be 2 cycles.
REQ-022 In SEND, on handshake with address below REG_COUNT-1:
- The address SHALL increment by 1.
- The FSM SHALL return to LOAD.
- dump_valid_o SHALL drop for exactly one cycle.
REQ-023 In SEND, on handshake with address equal to REG_COUNT-1, the FSM SHALL enter DONE; with the macro defined it SHALL enter CHECK instead.
REQ-024 dump_last_o SHALL be 1 only on the final beat of the dump.
REQ-025 In DONE, done_o SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-026 The address counter SHALL NOT wrap past REG_COUNT-1 within a dump.
REQ-027 Register file writes occurring during a dump SHALL be reflected only if they happen before the LOAD cycle of the affected index.
REQ-028 dump_ready_i held low SHALL stall SEND indefinitely with no loss of data.

Reset
REQ-029 On reset=1 at a clock edge, the following SHALL be set:
- FSM to IDLE.
- Address counter to 0.
- All outputs to 0, including Read_Register_o.
- Checksum accumulator to 0.
REQ-030 Reset asserted mid-dump SHALL abort the dump without pulsing done_o.

Configuration
REQ-031 The macro DUMP_CHECKSUM_EN SHALL control the checksum feature.
REQ-032 With DUMP_CHECKSUM_EN defined:
- An N-bit XOR accumulator SHALL be cleared on start and SHALL XOR in each LOAD-captured word.
- After beat REG_COUNT-1, CHECK SHALL present one extra beat with dump_data_o = accumulator, dump_index_o = 0 and dump_last_o = 1.
- On handshake, CHECK SHALL enter DONE.
REQ-033 Without DUMP_CHECKSUM_EN:
- The CHECK state and the accumulator SHALL NOT exist.
- dump_last_o SHALL be asserted on index REG_COUNT-1.

Structure
REQ-034 The state encodings and the REG_COUNT default SHALL live in the shared package reg_dump_pkg.
REQ-035 The XOR accumulator SHALL be the sub-module reg_dump_xor_accum, instantiated only under DUMP_CHECKSUM_EN.
REQ-036 The block SHALL connect to one read port of Register_File with no modification to Register_File.

Verification
REQ-037 Pulse start with registers preloaded (x0=0, x2=0x1001_03FC, xk=k otherwise) and dump_ready_i=1 -> 32 beats in order 0..31 with matching data, last on 31, done_o 1 cycle later.
REQ-038 Hold dump_ready_i=0 for 5 cycles during beat 7 -> dump_valid_o high throughout and data/index stable at index 7.
REQ-039 Pulse start_i again at beat 10 -> ignored, sequence continues unchanged.
REQ-040 Assert reset at beat 15 -> next cycle busy_o=0 and dump_valid_o=0, no done_o; a new start dumps again from index 0.
REQ-041 With DUMP_CHECKSUM_EN defined and xk=k -> 33rd beat data = XOR(0..31, with x2 value) and index 0 with last=1.
REQ-042 Write x5=0xDEADBEEF before beat 5 LOAD -> beat 5 carries 0xDEADBEEF.
